// File: rtl/output_allocator_pkg.sv
// Shared NoC definitions used by the output allocator: port index width,
// mesh direction encoding and the per-output-port allocation state.
package output_allocator_pkg;

    localparam int NOC_PORTS = 5;
    localparam int IDX_WIDTH = $clog2(NOC_PORTS);

    typedef enum logic [IDX_WIDTH-1:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_SOUTH = 3'd2,
        DIR_EAST  = 3'd3,
        DIR_WEST  = 3'd4
    } port_dir_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/output_allocator_rr_pick.sv
// Round-robin picker: returns the first asserted request at or after the
// pointer, wrapping from N-1 back to 0. One-hot grant plus its index.
module rr_pick #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);

    int   cand_s;
    logic found_s;

    // Scan candidates starting at the pointer; first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = int'(ptr_i) + k;
            if (cand_s >= N) begin
                cand_s = cand_s - N;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_i[cand_s]) begin
                found_s       = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/output_allocator.sv
// Output allocator: one IDLE/BUSY owner FSM per output port with
// round-robin arbitration, packet-end release and beat-count forced release.
module output_allocator #(
    parameter int CHANNEL_NUMBER   = 5,
    parameter int MAX_PACKET_BEATS = 16,
    parameter int IDX_WIDTH        = $clog2(CHANNEL_NUMBER)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [CHANNEL_NUMBER-1:0]                req_valid_i,
    input  logic [CHANNEL_NUMBER-1:0][IDX_WIDTH-1:0] req_port_i,
    input  logic [CHANNEL_NUMBER-1:0]                out_fire_i,
    input  logic [CHANNEL_NUMBER-1:0]                out_last_i,
    output logic [CHANNEL_NUMBER-1:0]                grant_o,
    output logic [CHANNEL_NUMBER-1:0]                sel_valid_o,
    output logic [CHANNEL_NUMBER-1:0][IDX_WIDTH-1:0] sel_idx_o,
    output logic [CHANNEL_NUMBER-1:0]                timeout_o
);
    import output_allocator_pkg::*;

    localparam int                   CNT_WIDTH = $clog2(MAX_PACKET_BEATS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_PACKET_BEATS - 1);

    alloc_state_e                             state_r    [CHANNEL_NUMBER];
    alloc_state_e                             state_s    [CHANNEL_NUMBER];
    logic [IDX_WIDTH-1:0]                     rr_ptr_r   [CHANNEL_NUMBER];
    logic [IDX_WIDTH-1:0]                     rr_ptr_s   [CHANNEL_NUMBER];
    logic [CNT_WIDTH-1:0]                     beat_cnt_r [CHANNEL_NUMBER];
    logic [CNT_WIDTH-1:0]                     beat_cnt_s [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0]                req_vec_s  [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0]                pick_gnt_s [CHANNEL_NUMBER];
    logic [IDX_WIDTH-1:0]                     pick_idx_s [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0]                pick_any_s;
    logic [CHANNEL_NUMBER-1:0][IDX_WIDTH-1:0] sel_idx_r;
    logic [CHANNEL_NUMBER-1:0][IDX_WIDTH-1:0] sel_idx_s;
    logic [CHANNEL_NUMBER-1:0]                sel_valid_r;
    logic [CHANNEL_NUMBER-1:0]                sel_valid_s;
    logic [CHANNEL_NUMBER-1:0]                grant_r;
    logic [CHANNEL_NUMBER-1:0]                grant_s;
    logic [CHANNEL_NUMBER-1:0]                timeout_r;
    logic [CHANNEL_NUMBER-1:0]                timeout_s;

    // Pointer advance after a win, wrapping past the last channel.
    function automatic logic [IDX_WIDTH-1:0] ptr_after(input logic [IDX_WIDTH-1:0] idx);
        if (idx == IDX_WIDTH'(CHANNEL_NUMBER - 1)) begin
            ptr_after = '0;
        end else begin
            ptr_after = idx + IDX_WIDTH'(1);
        end
    endfunction

    // Per-port request vectors; a channel already owning a port cannot bid.
    always_comb begin
        for (int p = 0; p < CHANNEL_NUMBER; p++) begin
            req_vec_s[p] = '0;
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                req_vec_s[p][i] = req_valid_i[i] && (req_port_i[i] == IDX_WIDTH'(p)) && !grant_r[i];
            end
        end
    end

    for (genvar p = 0; p < CHANNEL_NUMBER; p++) begin : g_pick
        rr_pick #(
            .N (CHANNEL_NUMBER),
            .W (IDX_WIDTH)
        ) u_rr_pick (
            .req_i (req_vec_s[p]),
            .ptr_i (rr_ptr_r[p]),
            .gnt_o (pick_gnt_s[p]),
            .idx_o (pick_idx_s[p])
        );
        assign pick_any_s[p] = |pick_gnt_s[p];
    end

    // Next-state for every port FSM plus the registered-output images.
    always_comb begin
        grant_s = '0;
        for (int p = 0; p < CHANNEL_NUMBER; p++) begin
            state_s[p]    = state_r[p];
            rr_ptr_s[p]   = rr_ptr_r[p];
            beat_cnt_s[p] = beat_cnt_r[p];
            sel_idx_s[p]  = sel_idx_r[p];
            timeout_s[p]  = 1'b0;
            case (state_r[p])
                ST_IDLE: begin
                    if (pick_any_s[p]) begin
                        state_s[p]    = ST_BUSY;
                        sel_idx_s[p]  = pick_idx_s[p];
                        beat_cnt_s[p] = '0;
                        rr_ptr_s[p]   = ptr_after(pick_idx_s[p]);
                    end else begin
                        state_s[p] = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (out_fire_i[p]) begin
                        beat_cnt_s[p] = beat_cnt_r[p] + CNT_WIDTH'(1);
                        if (out_last_i[p]) begin
                            state_s[p] = ST_IDLE;
                        end else if (beat_cnt_r[p] == CNT_LIMIT) begin
                            state_s[p]   = ST_IDLE;
                            timeout_s[p] = 1'b1;
                        end else begin
                            state_s[p] = ST_BUSY;
                        end
                    end else begin
                        state_s[p] = ST_BUSY;
                    end
                end
                default: begin
                    state_s[p] = ST_IDLE;
                end
            endcase
            sel_valid_s[p] = (state_s[p] == ST_BUSY);
        end
        for (int p = 0; p < CHANNEL_NUMBER; p++) begin
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                grant_s[i] = grant_s[i] | (sel_valid_s[p] && (sel_idx_s[p] == IDX_WIDTH'(i)));
            end
        end
    end

    // State and output registers; reset drops all ownership immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < CHANNEL_NUMBER; p++) begin
                state_r[p]    <= ST_IDLE;
                rr_ptr_r[p]   <= '0;
                beat_cnt_r[p] <= '0;
            end
            sel_idx_r   <= '0;
            sel_valid_r <= '0;
            grant_r     <= '0;
            timeout_r   <= '0;
        end else begin
            for (int p = 0; p < CHANNEL_NUMBER; p++) begin
                state_r[p]    <= state_s[p];
                rr_ptr_r[p]   <= rr_ptr_s[p];
                beat_cnt_r[p] <= beat_cnt_s[p];
            end
            sel_idx_r   <= sel_idx_s;
            sel_valid_r <= sel_valid_s;
            grant_r     <= grant_s;
            timeout_r   <= timeout_s;
        end
    end

    assign grant_o     = grant_r;
    assign sel_valid_o = sel_valid_r;
    assign sel_idx_o   = sel_idx_r;
    assign timeout_o   = timeout_r;

endmodule

// File: doc/output_allocator.md
OUTPUT_ALLOCATOR -- requirements
Module: output_allocator

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER, default 5, the number of input channels and the number of output ports (local + 4 mesh directions).
REQ-002 SHALL have parameter MAX_PACKET_BEATS, default 16, the maximum beats one packet may hold an output before forced release.
REQ-003 SHALL have derived parameter IDX_WIDTH = $clog2(CHANNEL_NUMBER), the width of channel and port indices.
REQ-004 clk_i  input  1  single clock; all state rises on its posedge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 req_valid_i  input  [CHANNEL_NUMBER]  input channel i has a head-of-queue packet awaiting an output.
REQ-007 req_port_i  input  [CHANNEL_NUMBER][IDX_WIDTH]  output port requested by channel i, from the routing algorithm.
REQ-008 out_fire_i  input  [CHANNEL_NUMBER]  a beat transferred on output port p (TVALID and TREADY both high).
REQ-009 out_last_i  input  [CHANNEL_NUMBER]  TLAST of the beat on output port p, qualified by out_fire_i[p].
REQ-010 grant_o  output  [CHANNEL_NUMBER]  input channel i currently owns its requested output.
REQ-011 sel_valid_o  output  [CHANNEL_NUMBER]  output port p has an owner.
REQ-012 sel_idx_o  output  [CHANNEL_NUMBER][IDX_WIDTH]  index of the owning input of port p; drives the crossbar mux.
REQ-013 timeout_o  output  [CHANNEL_NUMBER]  one-cycle pulse: port p was force-released.

Function
REQ-014 SHALL keep an independent state machine per output port, states IDLE and BUSY.
REQ-015 IDLE -> BUSY SHALL occur when at least one channel has req_valid_i high and req_port_i equal to p, and that channel holds no grant on another port.
REQ-016 The winner SHALL be chosen round-robin: the first requester at or after rr_ptr[p], wrapping from CHANNEL_NUMBER-1 to 0.
REQ-017 Grant latency SHALL be one cycle: a request sampled at edge t gives sel_valid_o, sel_idx_o and grant_o high after edge t.
REQ-018 On grant, rr_ptr[p] SHALL be set to winner+1, wrapping to 0 past CHANNEL_NUMBER-1.
REQ-019 BUSY -> IDLE SHALL occur at the edge where out_fire_i[p] and out_last_i[p] are both high.
REQ-020 A released port SHALL stay IDLE for exactly one cycle, so the next grant appears two cycles after the last beat.
REQ-021 The beat counter beat_cnt[p] SHALL be cleared on grant and incremented on each out_fire_i[p] while BUSY; its width is $clog2(MAX_PACKET_BEATS+1).
REQ-022 Forced release: when out_fire_i[p] is high without last and beat_cnt[p] equals MAX_PACKET_BEATS-1, the port SHALL go IDLE and pulse timeout_o[p] for one cycle.
REQ-023 A last beat on the MAX_PACKET_BEATS-th beat SHALL be a normal release with no timeout.
REQ-024 grant_o[i] SHALL be high if and only if some BUSY port p has sel_idx_o[p] equal to i; at most one port per input.
REQ-025 Changes to req_port_i or req_valid_i while an input is granted SHALL NOT alter ownership; only last or timeout releases a port.
REQ-026 out_fire_i[p] while port p is IDLE SHALL be ignored and SHALL NOT update any state.
REQ-027 sel_idx_o[p] SHALL hold its last value while IDLE; consumers gate it with sel_valid_o[p].

Reset
REQ-028 While rst_i is high, every port SHALL be IDLE, with rr_ptr = 0, beat_cnt = 0, sel_idx_o = 0, and grant_o, sel_valid_o and timeout_o all 0.
REQ-029 Reset asserted mid-packet SHALL drop all ownership at once; after deassertion, arbitration restarts from rr_ptr = 0 with no memory of prior grants.

Structure
REQ-030 IDX_WIDTH and the port-direction encoding (LOCAL=0, NORTH, SOUTH, EAST, WEST) SHALL live in the shared NoC package, along with the state enum {IDLE, BUSY}.
REQ-031 A round-robin picker sub-module rr_pick SHALL be used, instantiated once per output port.
REQ-032 rr_pick SHALL take a request vector and a pointer, and return a one-hot grant plus an index, purely combinationally.

Verification
REQ-033 Single request: channel 2 requests port 3 at cycle 0 -> sel_valid_o[3]=1, sel_idx_o[3]=2 and grant_o[2]=1 from cycle 1.
REQ-034 Contention: channels 0, 1 and 4 request port 0 continuously, each sending 3-beat packets -> grant order 0, 1, 4, 0, with a one-cycle IDLE gap between packets.
REQ-035 Wrap-around: rr_ptr[1]=4 and channels 0 and 4 request -> 4 wins; rr_ptr[1] becomes 0; the next winner is 0.
REQ-036 Timeout: MAX_PACKET_BEATS=16 and 16 beats with no last -> timeout_o[p] pulses on the cycle after the 16th beat and the port is IDLE; a packet of exactly 16 beats ending in last -> no pulse.
REQ-037 Simultaneous ports: channel 1 requests port 2 and channel 3 requests port 4 in the same cycle -> both granted in cycle 1, independently.
REQ-038 Reset mid-packet: rst_i pulsed while port 0 is BUSY after 5 beats -> all outputs 0 asynchronously; a fresh request is granted one cycle after rst_i falls.
